dcache_mem_arbiter: RTL and testbench

Shares one memory-controller channel between the NUM_CONSUMERS miss/writeback ports of the data cache. Each cache port raises a line fill (read) or an eviction writeback (write). The arbiter grants one transaction at a time in round-robin order and forwards it to the controller. It returns the controller's response to the granted port with a one-cycle ready pulse. It sits between the dcache controller-side interface and a single memory controller channel.

---
 rtl/dcache_pkg.sv | 7 +
 rtl/rr_priority_picker.sv | 34 +++
 rtl/dcache_mem_arbiter.sv | 131 +++++++++++++
 tb/tb_dcache_mem_arbiter.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/dcache_pkg.sv
// dcache_pkg: shared types and constants for the dcache memory-channel arbiter
package dcache_pkg;
  localparam int NUM_CONSUMERS_DEFAULT = 8;
  localparam int GRANT_BITS = $clog2(NUM_CONSUMERS_DEFAULT);
  typedef enum logic [1:0] {IDLE, ISSUE, RESPOND, CLEAR} arb_state_t;
  typedef enum logic {OP_READ, OP_WRITE} mem_op_t;
endpackage

// File: rtl/rr_priority_picker.sv
// rr_priority_picker: finds the first set request at or after ptr, wrapping
//   req   in  N  request vector
//   ptr   in  W  starting position of the scan
//   found out 1  any request set
//   index out W  winning position
module rr_priority_picker
  import dcache_pkg::*;
#(
  parameter int N = NUM_CONSUMERS_DEFAULT,
  parameter int W = GRANT_BITS
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic         found,
  output logic [W-1:0] index
);
  logic [N-1:0] rot;
  int sum;
  // Rotating the request vector puts ptr at bit 0, so the lowest set bit of
  // rot is the winner; scanning downward lets the lowest offset overwrite.
  always_comb begin
    rot = N'({req, req} >> ptr);
    found = 1'b0;
    index = '0;
    sum = 0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) begin
        sum = int'(ptr) + i;
        found = 1'b1;
        index = W'(sum >= N ? sum - N : sum);
      end
    end
  end
endmodule

// File: rtl/dcache_mem_arbiter.sv
// dcache_mem_arbiter: round-robin share of one memory channel among dcache ports
//   clk, reset (async, active-low)
//   req_read_*  : per-port fill requests; ready pulses one cycle with data
//   req_write_* : per-port writeback requests; ready pulses one cycle
//   mem_read_*  : controller read channel (valid held until ready)
//   mem_write_* : controller write channel (valid held until ready)
module dcache_mem_arbiter
  import dcache_pkg::*;
#(
  parameter int ADDR_BITS     = 8,
  parameter int DATA_BITS     = 8,
  parameter int NUM_CONSUMERS = NUM_CONSUMERS_DEFAULT
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [NUM_CONSUMERS-1:0]             req_read_valid,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0]   req_read_address,
  output logic [NUM_CONSUMERS-1:0]             req_read_ready,
  output logic [NUM_CONSUMERS*DATA_BITS-1:0]   req_read_data,
  input  logic [NUM_CONSUMERS-1:0]             req_write_valid,
  input  logic [NUM_CONSUMERS*ADDR_BITS-1:0]   req_write_address,
  input  logic [NUM_CONSUMERS*DATA_BITS-1:0]   req_write_data,
  output logic [NUM_CONSUMERS-1:0]             req_write_ready,
  output logic                                 mem_read_valid,
  output logic [ADDR_BITS-1:0]                 mem_read_address,
  input  logic                                 mem_read_ready,
  input  logic [DATA_BITS-1:0]                 mem_read_data,
  output logic                                 mem_write_valid,
  output logic [ADDR_BITS-1:0]                 mem_write_address,
  output logic [DATA_BITS-1:0]                 mem_write_data,
  input  logic                                 mem_write_ready
);
  localparam int GW = $clog2(NUM_CONSUMERS);
  arb_state_t state_q, state_d;
  mem_op_t op_q, op_d;
  logic [GW-1:0] grant_q, grant_d, rr_q, rr_d, pick;
  logic found, pick_write, mem_done, grant_valid;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic [DATA_BITS-1:0] wdata_q, wdata_d;
  logic mem_rv_q, mem_rv_d, mem_wv_q, mem_wv_d;
  logic [NUM_CONSUMERS-1:0] rd_ready_q, rd_ready_d, wr_ready_q, wr_ready_d;
  logic [NUM_CONSUMERS*DATA_BITS-1:0] rd_data_q, rd_data_d;

  rr_priority_picker #(.N(NUM_CONSUMERS), .W(GW)) u_pick (
    .req   (req_read_valid | req_write_valid),
    .ptr   (rr_q),
    .found (found),
    .index (pick)
  );

  assign pick_write  = req_write_valid[pick];
  assign mem_done    = op_q == OP_WRITE ? mem_write_ready : mem_read_ready;
  assign grant_valid = op_q == OP_WRITE ? req_write_valid[grant_q] : req_read_valid[grant_q];

  always_comb begin
    state_d = state_q;
    op_d = op_q;
    grant_d = grant_q;
    rr_d = rr_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    mem_rv_d = mem_rv_q;
    mem_wv_d = mem_wv_q;
    rd_ready_d = '0;
    wr_ready_d = '0;
    rd_data_d = rd_data_q;
    case (state_q)
      IDLE: if (found) begin
        // Writeback beats fill within a port so the victim drains first.
        grant_d = pick;
        op_d = pick_write ? OP_WRITE : OP_READ;
        addr_d = pick_write ? req_write_address[int'(pick)*ADDR_BITS +: ADDR_BITS]
                            : req_read_address[int'(pick)*ADDR_BITS +: ADDR_BITS];
        wdata_d = req_write_data[int'(pick)*DATA_BITS +: DATA_BITS];
        mem_wv_d = pick_write;
        mem_rv_d = !pick_write;
        state_d = ISSUE;
      end
      ISSUE: if (mem_done) begin
        mem_rv_d = 1'b0;
        mem_wv_d = 1'b0;
        if (op_q == OP_READ) rd_data_d[int'(grant_q)*DATA_BITS +: DATA_BITS] = mem_read_data;
        rd_ready_d[grant_q] = op_q == OP_READ;
        wr_ready_d[grant_q] = op_q == OP_WRITE;
        state_d = RESPOND;
      end
      RESPOND: begin
        rr_d = grant_q == GW'(NUM_CONSUMERS - 1) ? '0 : grant_q + 1'b1;
        state_d = CLEAR;
      end
      default: state_d = grant_valid ? CLEAR : IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      op_q <= OP_READ;
      grant_q <= '0;
      rr_q <= '0;
      addr_q <= '0;
      wdata_q <= '0;
      mem_rv_q <= 1'b0;
      mem_wv_q <= 1'b0;
      rd_ready_q <= '0;
      wr_ready_q <= '0;
      rd_data_q <= '0;
    end else begin
      state_q <= state_d;
      op_q <= op_d;
      grant_q <= grant_d;
      rr_q <= rr_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      mem_rv_q <= mem_rv_d;
      mem_wv_q <= mem_wv_d;
      rd_ready_q <= rd_ready_d;
      wr_ready_q <= wr_ready_d;
      rd_data_q <= rd_data_d;
    end
  end

  assign req_read_ready    = rd_ready_q;
  assign req_write_ready   = wr_ready_q;
  assign req_read_data     = rd_data_q;
  assign mem_read_valid    = mem_rv_q;
  assign mem_write_valid   = mem_wv_q;
  assign mem_read_address  = addr_q;
  assign mem_write_address = addr_q;
  assign mem_write_data    = wdata_q;
endmodule

// File: tb/tb_dcache_mem_arbiter.sv
// tb_dcache_mem_arbiter: directed vector table plus multi-cycle corner sequences
module tb_dcache_mem_arbiter;
  logic clk = 0, reset = 0;
  logic [7:0] rv = '0, wv = '0, req_read_ready, req_write_ready;
  logic [63:0] ra = '0, wa = '0, wd = '0, req_read_data;
  logic mem_read_valid, mem_write_valid, mem_read_ready = 0, mem_write_ready = 0;
  logic [7:0] mem_read_address, mem_write_address, mem_write_data, mem_read_data = '0;
  int n_chk = 0, n_fail = 0, ng = 0;
  int gport[16], gcyc[16];

  typedef struct {
    int port; bit wv, rv; logic [7:0] waddr, wdata, raddr, mrdata; int lat;
    bit exp_w; logic [7:0] exp_addr, exp_wdata, exp_rdata;
  } vec_t;
  vec_t vecs[5];

  dcache_mem_arbiter dut (
    .clk(clk), .reset(reset),
    .req_read_valid(rv), .req_read_address(ra), .req_read_ready(req_read_ready),
    .req_read_data(req_read_data),
    .req_write_valid(wv), .req_write_address(wa), .req_write_data(wd),
    .req_write_ready(req_write_ready),
    .mem_read_valid(mem_read_valid), .mem_read_address(mem_read_address),
    .mem_read_ready(mem_read_ready), .mem_read_data(mem_read_data),
    .mem_write_valid(mem_write_valid), .mem_write_address(mem_write_address),
    .mem_write_data(mem_write_data), .mem_write_ready(mem_write_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) if (reset) chk("mem_mutex", mem_read_valid & mem_write_valid, 0);

  task automatic wait_mem(output bit ok);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(mem_read_valid | mem_write_valid) && n < 10);
    ok = mem_read_valid | mem_write_valid;
  endtask

  task automatic respond(input int lat, input logic [7:0] rdata, input bit is_w);
    repeat (lat - 1) begin
      @(negedge clk);
      chk("valid_hold", is_w ? mem_write_valid : mem_read_valid, 1);
      chk("no_early_ready", {req_write_ready, req_read_ready}, 0);
    end
    mem_read_data = rdata;
    if (is_w) mem_write_ready = 1; else mem_read_ready = 1;
    @(negedge clk);
    mem_read_ready = 0;
    mem_write_ready = 0;
  endtask

  task automatic run_vec(input vec_t v);
    bit ok;
    logic [7:0] oh;
    @(negedge clk);
    if (v.wv) begin wv[v.port] = 1; wa[v.port*8 +: 8] = v.waddr; wd[v.port*8 +: 8] = v.wdata; end
    if (v.rv) begin rv[v.port] = 1; ra[v.port*8 +: 8] = v.raddr; end
    wait_mem(ok);
    chk("issue_seen", ok, 1);
    chk("mem_write_valid", mem_write_valid, v.exp_w);
    chk("mem_read_valid", mem_read_valid, !v.exp_w);
    chk("mem_addr", v.exp_w ? mem_write_address : mem_read_address, v.exp_addr);
    if (v.exp_w) chk("mem_wdata", mem_write_data, v.exp_wdata);
    respond(v.lat, v.mrdata, v.exp_w);
    oh = 8'(1) << v.port;
    chk("wr_ready", req_write_ready, v.exp_w ? oh : 8'h00);
    chk("rd_ready", req_read_ready, v.exp_w ? 8'h00 : oh);
    chk("mem_valid_cleared", {mem_read_valid, mem_write_valid}, 0);
    if (!v.exp_w) chk("rd_data", req_read_data[v.port*8 +: 8], v.exp_rdata);
    @(negedge clk);
    chk("ready_one_cycle", {req_write_ready, req_read_ready}, 0);
    if (v.exp_w) wv[v.port] = 0; else rv[v.port] = 0;
    repeat (2) @(negedge clk);
  endtask

  // Automatic requesters and a 1-cycle memory; each port drops its read on
  // its ready pulse and optionally re-raises it two cycles later.
  task automatic auto_serve(input int want, input bit reraise);
    int cyc = 0;
    int back[8];
    ng = 0;
    for (int i = 0; i < 8; i++) back[i] = -1;
    while (ng < want && cyc < 200) begin
      @(negedge clk);
      cyc++;
      chk("ready_onehot", $countones(req_read_ready) <= 1, 1);
      for (int i = 0; i < 8; i++) begin
        if (req_read_ready[i]) begin
          if (ng < 16) begin gport[ng] = i; gcyc[ng] = cyc; end
          chk("auto_data", req_read_data[i*8 +: 8], ra[i*8 +: 8] ^ 8'hFF);
          ng++;
          rv[i] = 0;
          back[i] = reraise ? cyc + 2 : -1;
        end else if (back[i] == cyc) rv[i] = 1;
      end
      mem_read_data = mem_read_address ^ 8'hFF;
      mem_read_ready = mem_read_valid;
    end
    mem_read_ready = 0;
    chk("auto_grants", ng >= want, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    vecs[0] = '{3, 0, 1, 8'h00, 8'h00, 8'h5A, 8'hC3, 2, 0, 8'h5A, 8'h00, 8'hC3};
    vecs[1] = '{1, 1, 1, 8'h10, 8'h77, 8'h20, 8'h00, 1, 1, 8'h10, 8'h77, 8'h00};
    vecs[2] = '{1, 0, 0, 8'h00, 8'h00, 8'h00, 8'h3E, 1, 0, 8'h20, 8'h00, 8'h3E};
    vecs[3] = '{0, 1, 0, 8'hFF, 8'h01, 8'h00, 8'h00, 3, 1, 8'hFF, 8'h01, 8'h00};
    vecs[4] = '{7, 0, 1, 8'h00, 8'h00, 8'h81, 8'hA5, 1, 0, 8'h81, 8'h00, 8'hA5};
    repeat (2) @(negedge clk);
    chk("reset_mem_valid", {mem_read_valid, mem_write_valid}, 0);
    chk("reset_ready", {req_write_ready, req_read_ready}, 0);
    chk("reset_rdata", req_read_data, 0);
    chk("reset_addr", mem_read_address, 0);
    reset = 1;
    for (int k = 0; k < 5; k++) run_vec(vecs[k]);

    // round robin with every port requesting
    for (int i = 0; i < 8; i++) ra[i*8 +: 8] = 8'h40 + 8'(i);
    @(negedge clk);
    rv = 8'hFF;
    auto_serve(9, 1);
    rv = 8'h00;
    for (int k = 0; k < 9; k++) begin
      chk("rr_order", gport[k], k % 8);
      if (k > 0) chk("rr_spacing", gcyc[k] - gcyc[k-1], 4);
    end
    repeat (3) @(negedge clk);

    // stale request held past ready must not be granted again
    ra[2*8 +: 8] = 8'h33;
    rv[2] = 1;
    wait_mem(ok);
    chk("stale_issue", ok, 1);
    chk("stale_addr", mem_read_address, 8'h33);
    respond(1, 8'h99, 0);
    chk("stale_ready", req_read_ready, 8'h04);
    chk("stale_data", req_read_data[2*8 +: 8], 8'h99);
    repeat (3) begin
      @(negedge clk);
      chk("stale_no_reissue", mem_read_valid, 0);
    end
    rv[2] = 0;
    repeat (2) begin
      @(negedge clk);
      chk("stale_idle", mem_read_valid, 0);
    end
    rv[2] = 1;
    wait_mem(ok);
    chk("stale_reraise", ok, 1);
    respond(1, 8'h11, 0);
    chk("stale_ready2", req_read_ready, 8'h04);
    rv[2] = 0;
    repeat (3) @(negedge clk);

    // async reset during ISSUE, then a late memory ready
    ra[5*8 +: 8] = 8'h66;
    rv[5] = 1;
    wait_mem(ok);
    chk("rst_issue", ok, 1);
    #2 reset = 0;
    #1;
    chk("rst_async_valid", {mem_read_valid, mem_write_valid}, 0);
    chk("rst_async_addr", mem_read_address, 0);
    chk("rst_async_rdata", req_read_data, 0);
    chk("rst_async_ready", {req_write_ready, req_read_ready}, 0);
    @(negedge clk);
    rv[5] = 0;
    mem_read_ready = 1;
    @(negedge clk);
    reset = 1;
    repeat (3) begin
      @(negedge clk);
      chk("rst_late_ready", {req_write_ready, req_read_ready}, 0);
      chk("rst_idle", {mem_read_valid, mem_write_valid}, 0);
    end
    mem_read_ready = 0;

    // wrap: grant port 6 so the pointer sits at 7, then race ports 0 and 7
    rv[6] = 1;
    auto_serve(1, 0);
    chk("wrap_pre", gport[0], 6);
    repeat (3) @(negedge clk);
    rv[0] = 1;
    rv[7] = 1;
    auto_serve(2, 0);
    chk("wrap_first", gport[0], 7);
    chk("wrap_second", gport[1], 0);
    repeat (3) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
